// File: rtl/itree_config_loader.sv
// Byte-serial configuration loader: assembles a checksummed frame into the tree image and
// commits it with a one-cycle load pulse. Frames that fail for any reason leave the image as-is.
module itree_config_loader #(
  parameter int unsigned TREE_W   = 256,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cfg_byte,
  input  logic              cfg_valid,
  input  logic              cfg_last,
  output logic              cfg_ready,
  output logic [TREE_W-1:0] itree_input,
  output logic              load_itree,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  localparam int unsigned NBYTES = TREE_W / 8;
  localparam int unsigned CW     = $clog2(NBYTES) + 1;
  localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StCheck,
    StDrain,
    StCommit
  } state_e;

  state_e                  r_state;
  logic [CW-1:0]           r_count;
  logic [TW-1:0]           r_tmo;
  logic [7:0]              r_xor;
  logic [NBYTES-1:0][7:0]  r_staging;
  logic [TREE_W-1:0]       r_itree;
  logic                    r_load;
  logic                    r_error;
  logic                    r_busy;

  logic                    w_xfer;
  logic                    w_tmo_hit;

  // Ready is a pure state decode, held low while reset is asserted.
  assign cfg_ready = reset && (r_state != StCommit);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_tmo     <= '0;
      r_xor     <= '0;
      r_staging <= '0;
      r_itree   <= '0;
      r_load    <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_xfer && (cfg_byte == HDR_BYTE)) begin
            if (cfg_last) begin
              r_error <= 1'b1;
            end else begin
              r_state <= StPayload;
              r_busy  <= 1'b1;
              r_count <= '0;
              r_xor   <= '0;
              r_tmo   <= '0;
              r_error <= 1'b0;
            end
          end
        end

        StPayload: begin
          if (w_xfer) begin
            r_tmo                     <= '0;
            r_staging[r_count[IW-1:0]] <= cfg_byte;
            r_xor                     <= r_xor ^ cfg_byte;
            r_count                   <= r_count + 1'b1;
            if (cfg_last) begin
              r_error <= 1'b1;
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else if (r_count == CW'(NBYTES - 1)) begin
              r_state <= StCheck;
            end
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        StCheck: begin
          if (w_xfer) begin
            r_tmo <= '0;
            if (cfg_last && (cfg_byte == r_xor)) begin
              r_state <= StCommit;
              r_itree <= r_staging;
              r_load  <= 1'b1;
            end else if (cfg_last) begin
              r_error <= 1'b1;
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_error <= 1'b1;
              r_state <= StDrain;
            end
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        StDrain: begin
          if (w_xfer && cfg_last) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end

        StCommit: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign itree_input = r_itree;
  assign load_itree  = r_load;
  assign load_done   = r_load;
  assign load_error  = r_error;
  assign busy        = r_busy;

endmodule
